// File: rtl/voq_out_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : voq_out_rr_scheduler
// Description : Per-output-port scheduler for the shared-memory switch.
//               It arbitrates round-robin between PORT_NUB input-side VOQs
//               that hold packets for this output. A grant lasts for a whole
//               packet, so packets never interleave on the output. A watchdog
//               revokes a grant whose VOQ stalls while the output is ready.
// Ports       : clk          system clock
//               rst_n        asynchronous active-low reset
//               req          per-VOQ request (VOQ holds >= 1 packet)
//               beat_in      one word moved from the granted VOQ this cycle
//               eop_in       qualifies beat_in: last word of the packet
//               out_ready    output port can accept a word this cycle
//               grant        one-hot grant, all-zero when idle
//               grant_idx    binary index of the granted VOQ
//               grant_valid  a grant is held
//               timeout_err  one-cycle pulse when the watchdog revokes
//               pkt_cnt      completed packets, saturating at 16'hFFFF
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 8
`endif

module voq_out_rr_scheduler #(
    parameter int PORT_NUB  = `PORT_NUB_TOTAL,
    parameter int WIDTH_SEL = $clog2(PORT_NUB),
    parameter int TIMEOUT   = 256,
    parameter int WIDTH_TO  = $clog2(TIMEOUT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PORT_NUB-1:0]  req,
    input  logic                 beat_in,
    input  logic                 eop_in,
    input  logic                 out_ready,
    output logic [PORT_NUB-1:0]  grant,
    output logic [WIDTH_SEL-1:0] grant_idx,
    output logic                 grant_valid,
    output logic                 timeout_err,
    output logic [15:0]          pkt_cnt
);

    localparam logic [0:0]           c_st_idle   = 1'b0;
    localparam logic [0:0]           c_st_busy   = 1'b1;
    localparam logic [PORT_NUB-1:0]  c_onehot0   = {{(PORT_NUB-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_SEL-1:0] c_last_port = WIDTH_SEL'(PORT_NUB - 1);
    localparam logic [WIDTH_SEL:0]   c_port_nub  = (WIDTH_SEL+1)'(PORT_NUB);
    localparam logic [WIDTH_TO-1:0]  c_wd_last   = WIDTH_TO'(TIMEOUT - 1);
    localparam logic [15:0]          c_cnt_max   = 16'hFFFF;

    logic [0:0]           r_state;
    logic [WIDTH_SEL-1:0] r_ptr;
    logic [WIDTH_TO-1:0]  r_wd;

    logic [WIDTH_SEL-1:0]   w_base;
    logic [WIDTH_SEL-1:0]   w_start;
    logic [PORT_NUB-1:0]    w_cand;
    logic [2*PORT_NUB-1:0]  w_dbl;
    logic [2*PORT_NUB-1:0]  w_shifted;
    logic [PORT_NUB-1:0]    w_rot;
    logic [WIDTH_SEL-1:0]   w_off;
    logic [WIDTH_SEL:0]     w_sum;
    logic [WIDTH_SEL-1:0]   w_win;
    logic                   w_any;

    // Round-robin winner. In IDLE the search starts after the pointer; in
    // BUSY it starts after the current owner and excludes it, which is what
    // the eop regrant needs. Candidates are rotated so the search start sits
    // at bit 0, a fixed priority encoder picks the lowest set bit, and the
    // offset is added back modulo PORT_NUB.
    always_comb begin
        w_base    = (r_state == c_st_busy) ? grant_idx : r_ptr;
        w_cand    = (r_state == c_st_busy) ? (req & ~grant) : req;
        w_any     = |w_cand;
        w_start   = (w_base == c_last_port) ? '0 : (w_base + 1'b1);
        w_dbl     = {w_cand, w_cand};
        w_shifted = w_dbl >> w_start;
        w_rot     = w_shifted[PORT_NUB-1:0];
        w_off     = '0;
        for (int i = PORT_NUB - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = WIDTH_SEL'(i);
            end
        end
        w_sum = {1'b0, w_start} + {1'b0, w_off};
        if (w_sum >= c_port_nub) begin
            w_sum = w_sum - c_port_nub;
        end
        w_win = w_sum[WIDTH_SEL-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_ptr       <= c_last_port;
            r_wd        <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout_err <= 1'b0;
            pkt_cnt     <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    // Beats seen while idle belong to nobody and are dropped.
                    if (w_any) begin
                        grant       <= c_onehot0 << w_win;
                        grant_idx   <= w_win;
                        grant_valid <= 1'b1;
                        r_wd        <= '0;
                        r_state     <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    if (beat_in) begin
                        // A beat always clears the watchdog, so eop beats a
                        // timeout that would otherwise fire on this cycle.
                        r_wd <= '0;
                        if (eop_in) begin
                            r_ptr <= grant_idx;
                            if (pkt_cnt != c_cnt_max) begin
                                pkt_cnt <= pkt_cnt + 16'd1;
                            end
                            if (w_any) begin
                                grant     <= c_onehot0 << w_win;
                                grant_idx <= w_win;
                            end else begin
                                grant       <= '0;
                                grant_valid <= 1'b0;
                                r_state     <= c_st_idle;
                            end
                        end
                    end else if (out_ready) begin
                        // Only an idle-but-ready output counts as a stall;
                        // back-pressure freezes the watchdog.
                        if (r_wd == c_wd_last) begin
                            r_ptr       <= grant_idx;
                            r_wd        <= '0;
                            grant       <= '0;
                            grant_valid <= 1'b0;
                            timeout_err <= 1'b1;
                            r_state     <= c_st_idle;
                        end else begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_voq_out_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_voq_out_rr_scheduler
// Description : Self-checking bench for voq_out_rr_scheduler. Directed
//               scenarios plus a randomized run compared cycle by cycle
//               against a behavioural model of the scheduling rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voq_out_rr_scheduler;

    localparam int N  = 8;
    localparam int TO = 256;
    localparam int WS = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic          beat_in;
    logic          eop_in;
    logic          out_ready;
    logic [N-1:0]  grant;
    logic [WS-1:0] grant_idx;
    logic          grant_valid;
    logic          timeout_err;
    logic [15:0]   pkt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: who owns the output, who was served last,
    // how many stall cycles have accumulated, packets completed.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_stall;
    int m_pkts;
    bit m_to;

    always #5 clk = ~clk;

    voq_out_rr_scheduler #(
        .PORT_NUB (N),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .beat_in     (beat_in),
        .eop_in      (eop_in),
        .out_ready   (out_ready),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout_err (timeout_err),
        .pkt_cnt     (pkt_cnt)
    );

    // First requester found walking the ports in order last+1, last+2, ...
    function automatic int rr_pick(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (last + k) % N;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = N - 1;
        m_stall = 0;
        m_pkts  = 0;
        m_to    = 0;
    endtask

    task automatic model_clock();
        logic [N-1:0] others;
        m_to = 0;
        if (!m_busy) begin
            if (req != '0) begin
                m_owner = rr_pick(req, m_last);
                m_busy  = 1;
                m_stall = 0;
            end
        end else if (beat_in) begin
            m_stall = 0;
            if (eop_in) begin
                m_last = m_owner;
                if (m_pkts < 65535) m_pkts++;
                others = req;
                others[m_owner] = 1'b0;
                if (others != '0) m_owner = rr_pick(others, m_owner);
                else              m_busy  = 0;
            end
        end else if (out_ready) begin
            m_stall++;
            if (m_stall == TO) begin
                m_busy  = 0;
                m_to    = 1;
                m_last  = m_owner;
                m_stall = 0;
            end
        end
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then move 1 time unit past the edge for sampling.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_clock();
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req       = '0;
        beat_in   = 1'b0;
        eop_in    = 1'b0;
        out_ready = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req     = '0;
        beat_in = 1'b1;
        eop_in  = 1'b1;
        if (m_busy) step();
        beat_in = 1'b0;
        eop_in  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req = '0; beat_in = 1'b0; eop_in = 1'b0; out_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (grant !== '0 || grant_valid !== 1'b0 || grant_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_grant: grant=%b valid=%b idx=%0d expected 0/0/0", grant, grant_valid, grant_idx);
        end
        n_checks++;
        if (timeout_err !== 1'b0 || pkt_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_status: timeout_err=%b pkt_cnt=%0d expected 0/0", timeout_err, pkt_cnt);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Beats while idle are ignored.
        beat_in = 1'b1; eop_in = 1'b1;
        step();
        step();
        beat_in = 1'b0; eop_in = 1'b0;
        n_checks++;
        if (pkt_cnt !== 16'd0 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_beat_ignored: pkt_cnt=%0d valid=%b expected 0/0", pkt_cnt, grant_valid);
        end
    endtask

    task automatic test_rr_pattern();
        int exp_seq [4];
        bit bubble;
        exp_seq = '{0, 2, 0, 2};
        apply_reset();
        req = 8'b0000_0101;
        step();
        bubble = 0;
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (grant_valid !== 1'b1 || grant_idx !== WS'(exp_seq[p]) || grant !== (N'(1) << exp_seq[p])) begin
                n_fail++;
                $display("FAIL rr_sequence[%0d]: valid=%b idx=%0d grant=%b expected idx %0d", p, grant_valid, grant_idx, grant, exp_seq[p]);
            end
            for (int b = 0; b < 3; b++) begin
                beat_in = 1'b1;
                eop_in  = (b == 2);
                step();
                if (grant_valid !== 1'b1) bubble = 1;
            end
        end
        beat_in = 1'b0; eop_in = 1'b0;
        n_checks++;
        if (bubble) begin
            n_fail++;
            $display("FAIL rr_no_bubble: grant_valid dropped=1 expected 0");
        end
        n_checks++;
        if (pkt_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL rr_pkt_cnt: pkt_cnt=%0d expected 4", pkt_cnt);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req = 8'b0001_0000;
        #1;
        n_checks++;
        if (grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_latency_pre: valid=%b expected 0", grant_valid);
        end
        step();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== WS'(4)) begin
            n_fail++;
            $display("FAIL b2b_first_grant: valid=%b idx=%0d expected 1/4", grant_valid, grant_idx);
        end
        beat_in = 1'b1; eop_in = 1'b0; step();
        eop_in = 1'b1; step();
        beat_in = 1'b0; eop_in = 1'b0;
        n_checks++;
        if (grant_valid !== 1'b0 || grant !== '0) begin
            n_fail++;
            $display("FAIL b2b_bubble: valid=%b grant=%b expected 0/0", grant_valid, grant);
        end
        step();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== WS'(4)) begin
            n_fail++;
            $display("FAIL b2b_regrant: valid=%b idx=%0d expected 1/4", grant_valid, grant_idx);
        end
        beat_in = 1'b1; eop_in = 1'b1; step();
        req = '0; step();
        beat_in = 1'b0; eop_in = 1'b0;
        n_checks++;
        if (grant_valid !== 1'b0 || pkt_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b_end: valid=%b pkt_cnt=%0d expected 0/2", grant_valid, pkt_cnt);
        end
    endtask

    task automatic test_timeout();
        bit early;
        apply_reset();
        req = 8'b0000_0010;
        step();
        req = 8'b0000_0110;
        early = 0;
        for (int c = 0; c < TO - 1; c++) begin
            step();
            if (timeout_err !== 1'b0 || grant_valid !== 1'b1) early = 1;
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL timeout_early: premature revoke=1 expected 0");
        end
        step();
        n_checks++;
        if (timeout_err !== 1'b1 || grant_valid !== 1'b0 || pkt_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL timeout_fire: err=%b valid=%b pkt_cnt=%0d expected 1/0/0", timeout_err, grant_valid, pkt_cnt);
        end
        step();
        n_checks++;
        if (timeout_err !== 1'b0 || grant_valid !== 1'b1 || grant_idx !== WS'(2)) begin
            n_fail++;
            $display("FAIL timeout_next: err=%b valid=%b idx=%0d expected 0/1/2", timeout_err, grant_valid, grant_idx);
        end
        // Stall to the brink, then eop on the cycle a timeout would occur.
        repeat (TO - 1) step();
        beat_in = 1'b1; eop_in = 1'b1; req = '0;
        step();
        beat_in = 1'b0; eop_in = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b0 || pkt_cnt !== 16'd1 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL eop_beats_timeout: err=%b pkt_cnt=%0d valid=%b expected 0/1/0", timeout_err, pkt_cnt, grant_valid);
        end
    endtask

    task automatic test_backpressure();
        bit bad;
        apply_reset();
        req = 8'b0000_1000;
        step();
        out_ready = 1'b0;
        bad = 0;
        repeat (1000) begin
            step();
            if (timeout_err !== 1'b0 || grant_valid !== 1'b1 || grant_idx !== WS'(3)) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_hold: grant lost or err under back-pressure=1 expected 0");
        end
        out_ready = 1'b1; beat_in = 1'b1; eop_in = 1'b1;
        step();
        beat_in = 1'b0; eop_in = 1'b0;
        n_checks++;
        if (pkt_cnt !== 16'd1 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_eop: pkt_cnt=%0d valid=%b expected 1/0", pkt_cnt, grant_valid);
        end
        // Watchdog must hold its count across back-pressure, not clear.
        step();
        repeat (200) step();
        out_ready = 1'b0;
        repeat (1000) step();
        out_ready = 1'b1;
        bad = 0;
        repeat (TO - 201) begin
            step();
            if (timeout_err !== 1'b0) bad = 1;
        end
        step();
        n_checks++;
        if (bad || timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_wd_hold: early=%b err=%b expected 0/1", bad, timeout_err);
        end
        drain();
    endtask

    task automatic test_req_drop();
        apply_reset();
        req = 8'b0000_0001;
        step();
        req = 8'b0000_1010;
        beat_in = 1'b1; eop_in = 1'b0;
        repeat (3) step();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== WS'(0)) begin
            n_fail++;
            $display("FAIL drop_hold: valid=%b idx=%0d expected 1/0", grant_valid, grant_idx);
        end
        eop_in = 1'b1;
        step();
        beat_in = 1'b0; eop_in = 1'b0;
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== WS'(1) || grant !== 8'b0000_0010) begin
            n_fail++;
            $display("FAIL drop_next: valid=%b idx=%0d grant=%b expected 1/1/00000010", grant_valid, grant_idx, grant);
        end
        drain();
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 8'hFF;
        step();
        beat_in = 1'b1; eop_in = 1'b1;
        step();
        eop_in = 1'b0;
        step();
        beat_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (grant !== '0 || grant_valid !== 1'b0 || pkt_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: grant=%b valid=%b pkt_cnt=%0d expected 0/0/0", grant, grant_valid, pkt_cnt);
        end
        model_reset();
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== WS'(0) || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_grant: valid=%b idx=%0d err=%b expected 1/0/0", grant_valid, grant_idx, timeout_err);
        end
        drain();
    endtask

    task automatic test_random();
        int pct_beat;
        logic [N-1:0] exp_grant;
        apply_reset();
        for (int blk = 0; blk < 12; blk++) begin
            case (blk % 3)
                0:       pct_beat = 60;
                1:       pct_beat = 10;
                default: pct_beat = 0;
            endcase
            for (int c = 0; c < 300; c++) begin
                req       = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
                out_ready = ($urandom_range(0, 9) != 0);
                beat_in   = ($urandom_range(0, 99) < pct_beat);
                eop_in    = ($urandom_range(0, 3) == 0);
                step();
                exp_grant = m_busy ? (N'(1) << m_owner) : '0;
                n_checks++;
                if (grant !== exp_grant || grant_valid !== m_busy) begin
                    n_fail++;
                    $display("FAIL rand_grant: grant=%b valid=%b expected %b/%b", grant, grant_valid, exp_grant, m_busy);
                end
                if (m_busy) begin
                    n_checks++;
                    if (grant_idx !== WS'(m_owner)) begin
                        n_fail++;
                        $display("FAIL rand_idx: idx=%0d expected %0d", grant_idx, m_owner);
                    end
                end
                n_checks++;
                if (timeout_err !== m_to || pkt_cnt !== 16'(m_pkts)) begin
                    n_fail++;
                    $display("FAIL rand_status: err=%b pkt_cnt=%0d expected %b/%0d", timeout_err, pkt_cnt, m_to, m_pkts);
                end
            end
        end
        beat_in = 1'b0; eop_in = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_rr_pattern();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_req_drop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
